// File: rtl/regfile_ctrl_if.sv
// Core-side bundle of regfile_ctrl: operand read request/response handshake plus the writeback port.
interface regfile_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            wb_we;
  logic [AW-1:0]   wb_wa;
  logic [XLEN-1:0] wb_wd;

  modport master (
    output req_valid, ra1, ra2, rd_ready, wb_we, wb_wa, wb_wd,
    input  req_ready, rd_valid, rd1, rd2
  );

  modport slave (
    input  req_valid, ra1, ra2, rd_ready, wb_we, wb_wa, wb_wd,
    output req_ready, rd_valid, rd1, rd2
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Sequencer in front of a BRAM register-file pair: zero-fills x1..x31 after reset, serves operand pairs
// with fixed 2-cycle latency and keeps x0 at zero. Macro REGFILE_CTRL_BYPASS_EN enables write forwarding.
module regfile_ctrl #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_ctrl_if.slave            core,
  output logic                     ram_we,
  output logic [$clog2(NREGS)-1:0] ram_wa,
  output logic [XLEN-1:0]          ram_wd,
  output logic [$clog2(NREGS)-1:0] ram_ra1,
  output logic [$clog2(NREGS)-1:0] ram_ra2,
  input  logic [XLEN-1:0]          ram_rd1,
  input  logic [XLEN-1:0]          ram_rd2,
  output logic                     init_done
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0]   ZERO_A = {AW{1'b0}};
  localparam logic [AW-1:0]   ONE_A  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   LAST_A = AW'(NREGS - 1);
  localparam logic [XLEN-1:0] ZERO_D = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   init_cnt_r;
  logic [AW-1:0]   ra1_r;
  logic [AW-1:0]   ra2_r;
  logic            init_done_r;
  logic            rd_valid_r;
  logic [XLEN-1:0] rd1_r;
  logic [XLEN-1:0] rd2_r;
  logic            req_ready_s;
  logic            accept_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;
`ifdef REGFILE_CTRL_BYPASS_EN
  logic            hit1_r;
  logic            hit2_r;
  logic [XLEN-1:0] hit_data_r;
`endif

  // BRAM write port: zero-fill sweep during INIT, filtered writeback afterwards, quiet in reset
  always_comb begin
    ram_we = 1'b0;
    ram_wa = core.wb_wa;
    ram_wd = core.wb_wd;
    if (!rst_n) begin
      ram_we = 1'b0;
    end else if (state_r == ST_INIT) begin
      ram_we = 1'b1;
      ram_wa = init_cnt_r;
      ram_wd = ZERO_D;
    end else begin
      ram_we = core.wb_we && (core.wb_wa != ZERO_A);
    end
  end

  // Request acceptance and BRAM read addressing
  always_comb begin
    case (state_r)
      ST_IDLE: req_ready_s = 1'b1;
      ST_RESP: req_ready_s = core.rd_ready;
      default: req_ready_s = 1'b0;
    endcase
`ifndef REGFILE_CTRL_BYPASS_EN
    // Without forwarding a read must not share its accept cycle with a write.
    req_ready_s = req_ready_s && !core.wb_we;
`endif
    accept_s = core.req_valid && req_ready_s;
    ram_ra1  = accept_s ? core.ra1 : ra1_r;
    ram_ra2  = accept_s ? core.ra2 : ra2_r;
  end

  // Operand resolution in READ: x0, then a same-cycle write, then the accept-cycle capture, then BRAM
  always_comb begin
    op1_s = ram_rd1;
    op2_s = ram_rd2;
    if (ra1_r == ZERO_A) begin
      op1_s = ZERO_D;
`ifdef REGFILE_CTRL_BYPASS_EN
    end else if (core.wb_we && (core.wb_wa == ra1_r)) begin
      op1_s = core.wb_wd;
    end else if (hit1_r) begin
      op1_s = hit_data_r;
`endif
    end else begin
      op1_s = ram_rd1;
    end
    if (ra2_r == ZERO_A) begin
      op2_s = ZERO_D;
`ifdef REGFILE_CTRL_BYPASS_EN
    end else if (core.wb_we && (core.wb_wa == ra2_r)) begin
      op2_s = core.wb_wd;
    end else if (hit2_r) begin
      op2_s = hit_data_r;
`endif
    end else begin
      op2_s = ram_rd2;
    end
  end

  // Sequencer state, latched addresses and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= ONE_A;
      init_done_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd1_r       <= ZERO_D;
      rd2_r       <= ZERO_D;
      ra1_r       <= ZERO_A;
      ra2_r       <= ZERO_A;
`ifdef REGFILE_CTRL_BYPASS_EN
      hit1_r      <= 1'b0;
      hit2_r      <= 1'b0;
      hit_data_r  <= ZERO_D;
`endif
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + ONE_A;
          if (init_cnt_r == LAST_A) begin
            state_r     <= ST_IDLE;
            init_done_r <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          rd1_r      <= op1_s;
          rd2_r      <= op2_s;
          rd_valid_r <= 1'b1;
          state_r    <= ST_RESP;
        end
        ST_RESP: begin
          if (core.rd_ready) begin
            rd_valid_r <= 1'b0;
            state_r    <= accept_s ? ST_READ : ST_IDLE;
          end else begin
`ifdef REGFILE_CTRL_BYPASS_EN
            // Held operands track writes to their source so a stalled consumer never sees stale data.
            if (core.wb_we && (core.wb_wa == ra1_r) && (ra1_r != ZERO_A)) begin
              rd1_r <= core.wb_wd;
            end
            if (core.wb_we && (core.wb_wa == ra2_r) && (ra2_r != ZERO_A)) begin
              rd2_r <= core.wb_wd;
            end
`endif
          end
        end
        default: state_r <= ST_INIT;
      endcase

      if (accept_s) begin
        ra1_r <= core.ra1;
        ra2_r <= core.ra2;
`ifdef REGFILE_CTRL_BYPASS_EN
        // BRAM returns old data on read-during-write, so keep the accept-cycle write value.
        hit1_r     <= core.wb_we && (core.wb_wa == core.ra1) && (core.ra1 != ZERO_A);
        hit2_r     <= core.wb_we && (core.wb_wa == core.ra2) && (core.ra2 != ZERO_A);
        hit_data_r <= core.wb_wd;
`endif
      end
    end
  end

  assign core.req_ready = req_ready_s;
  assign core.rd_valid  = rd_valid_r;
  assign core.rd1       = rd1_r;
  assign core.rd2       = rd2_r;
  assign init_done      = init_done_r;
endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl: BRAM pair model, architectural register model, directed and random traffic.
module tb_regfile_ctrl;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_ctrl_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  logic            ram_we;
  logic [AW-1:0]   ram_wa;
  logic [XLEN-1:0] ram_wd;
  logic [AW-1:0]   ram_ra1;
  logic [AW-1:0]   ram_ra2;
  logic [XLEN-1:0] ram_rd1;
  logic [XLEN-1:0] ram_rd2;
  logic            init_done;

  regfile_ctrl #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core      (bus),
    .ram_we    (ram_we),
    .ram_wa    (ram_wa),
    .ram_wd    (ram_wd),
    .ram_ra1   (ram_ra1),
    .ram_ra2   (ram_ra2),
    .ram_rd1   (ram_rd1),
    .ram_rd2   (ram_rd2),
    .init_done (init_done)
  );

  // BRAM pair: registered read, old data on read-during-write, garbage at power-up
  logic [XLEN-1:0] mem1 [NREGS];
  logic [XLEN-1:0] mem2 [NREGS];
  initial begin
    for (int i = 0; i < NREGS; i++) begin
      mem1[i] = $urandom;
      mem2[i] = $urandom;
    end
  end
  always @(posedge clk) begin
    if (ram_we) begin
      mem1[ram_wa] <= ram_wd;
      mem2[ram_wa] <= ram_wd;
    end
    ram_rd1 <= mem1[ram_ra1];
    ram_rd2 <= mem2[ram_ra2];
  end

  typedef struct {
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    int            acc;
  } req_t;

  req_t            q[$];
  logic [XLEN-1:0] ref_regs [NREGS];
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  bit              mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: architectural model of the register file; operands must match it whenever rd_valid is high
  always @(negedge clk) begin
    logic fv;
    logic exp_ready;
    logic exp_we;
    if (mon_en) begin
      fv        = (q.size() > 0) && (cyc >= q[0].acc + 2);
      exp_ready = (q.size() == 0) || (fv && bus.rd_ready);
`ifndef REGFILE_CTRL_BYPASS_EN
      exp_ready = exp_ready && !bus.wb_we;
      if (q.size() > 0 && bus.wb_we && bus.wb_wa != 5'd0)
        assert (bus.wb_wa != q[0].ra1 && bus.wb_wa != q[0].ra2)
          else $error("write hazard on pending source x%0d", bus.wb_wa);
`endif
      exp_we = bus.wb_we && (bus.wb_wa != 5'd0);
      chk("init_done_hold", XLEN'(init_done), XLEN'(1'b1));
      chk("rd_valid", XLEN'(bus.rd_valid), XLEN'(fv));
      chk("req_ready", XLEN'(bus.req_ready), XLEN'(exp_ready));
      chk("ram_we", XLEN'(ram_we), XLEN'(exp_we));
      if (exp_we) begin
        chk("ram_wa", XLEN'(ram_wa), XLEN'(bus.wb_wa));
        chk("ram_wd", ram_wd, bus.wb_wd);
      end
      if (fv) begin
        chk("rd1", bus.rd1, ref_regs[q[0].ra1]);
        chk("rd2", bus.rd2, ref_regs[q[0].ra2]);
        if (bus.rd_ready) void'(q.pop_front());
      end
      if (bus.req_valid && exp_ready) q.push_back('{ra1: bus.ra1, ra2: bus.ra2, acc: cyc});
      if (exp_we) ref_regs[bus.wb_wa] = bus.wb_wd;
    end
  end

  always @(negedge clk) begin
    if (rst_n && !init_done)
      assert (!bus.wb_we) else $error("writeback issued before init_done");
  end

  task automatic drive(input logic v, input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic rdy,
                       input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
    bus.req_valid = v;
    bus.ra1       = a1;
    bus.ra2       = a2;
    bus.rd_ready  = rdy;
    bus.wb_we     = we;
    bus.wb_wa     = wa;
    bus.wb_wd     = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.ra1       = 5'd0;
    bus.ra2       = 5'd0;
    bus.rd_ready  = 1'b1;
    bus.wb_we     = 1'b0;
    bus.wb_wa     = 5'd0;
    bus.wb_wd     = 32'd0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      n++;
    end
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0 after %0d cycles", q.size(), n);
      q.delete();
    end
  endtask

  task automatic do_reset_init();
    mon_en = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    for (int i = 0; i < NREGS; i++) ref_regs[i] = 32'd0;
    #1;
    chk("rst_rd_valid", XLEN'(bus.rd_valid), 32'd0);
    chk("rst_init_done", XLEN'(init_done), 32'd0);
    chk("rst_req_ready", XLEN'(bus.req_ready), 32'd0);
    chk("rst_ram_we", XLEN'(ram_we), 32'd0);
    chk("rst_rd1", bus.rd1, 32'd0);
    chk("rst_rd2", bus.rd2, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      chk("init_we", XLEN'(ram_we), 32'd1);
      chk("init_wa", XLEN'(ram_wa), XLEN'(i));
      chk("init_wd", ram_wd, 32'd0);
      chk("init_busy", XLEN'(init_done), 32'd0);
    end
    @(negedge clk);
    chk("init_done_set", XLEN'(init_done), 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] held1;
    logic [XLEN-1:0] held2;
    logic [XLEN-1:0] x9_val;
    idle_inputs();
    rst_n = 1'b1;
    #2;
    do_reset_init();

    // freshly zeroed register reads as 0
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 32'd0);
    drain();

    // write x3, then read x3/x0 with fixed latency
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x3_valid", XLEN'(bus.rd_valid), 32'd1);
    chk("x3_rd1", bus.rd1, 32'hDEADBEEF);
    chk("x3_rd2", bus.rd2, 32'd0);
    drain();

    // x0 is never written and reads back as 0
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h00001234);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    drain();

`ifdef REGFILE_CTRL_BYPASS_EN
    // write in the accept cycle, then a write while the response is stalled
    drive(1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("byp_accept_rd1", bus.rd1, 32'hA5A5A5A5);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h5A5A5A5A);
    chk("byp_resp_rd1", bus.rd1, 32'h5A5A5A5A);
    chk("byp_resp_rd2", bus.rd2, 32'hDEADBEEF);
    drain();
`endif

    // stalled consumer: outputs hold, then back-to-back accept
    x9_val = $urandom;
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, x9_val);
    drive(1'b1, 5'd9, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    held1 = bus.rd1;
    held2 = bus.rd2;
    chk("stall_rd1", held1, x9_val);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("hold_valid", XLEN'(bus.rd_valid), 32'd1);
      chk("hold_rd1", bus.rd1, held1);
      chk("hold_rd2", bus.rd2, held2);
    end
    drive(1'b1, 5'd2, 5'd9, 1'b1, 1'b0, 5'd0, 32'd0);
    drain();

    // randomized traffic with address collisions
    for (int n = 0; n < 1500; n++) begin
      logic          v;
      logic          rdy;
      logic          we;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [AW-1:0] wa;
      v   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      a1  = AW'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, 7));
      wa  = AW'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) wa = q[0].ra1;
`ifndef REGFILE_CTRL_BYPASS_EN
      if (q.size() > 0 && we && (wa == q[0].ra1 || wa == q[0].ra2)) we = 1'b0;
`endif
      drive(v, a1, a2, rdy, we, wa, $urandom);
    end
    drain();

    // reset while a read is in flight restarts initialisation
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0);
    do_reset_init();
    drive(1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("reinit_rd1", bus.rd1, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Sequencer between decode/writeback and the two-port BRAM register file (RAM256x32 pair, 1-cycle registered read).
- After reset, zero-initialises x1..x31, because BRAM contents are not reset.
- Converts decode read requests into a valid/ready handshake with fixed latency.
- Resolves write/read hazards around the BRAM's read-during-write behaviour (returns old data).
- Forces x0 to read as 0 and never writes x0.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count; address width = $clog2(NREGS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  decode presents ra1/ra2
- req_ready  out  1  controller accepts request
- ra1, ra2  in  5  source register addresses
- rd_valid  out  1  rd1/rd2 valid
- rd_ready  in  1  consumer takes rd1/rd2
- rd1, rd2  out  XLEN  operand data
- wb_we  in  1  writeback strobe
- wb_wa  in  5  writeback address
- wb_wd  in  XLEN  writeback data
- ram_we  out  1  BRAM write enable (to both BRAMs)
- ram_wa  out  5  BRAM write address
- ram_wd  out  XLEN  BRAM write data
- ram_ra1, ram_ra2  out  5  BRAM read addresses
- ram_rd1, ram_rd2  in  XLEN  BRAM read data, valid one cycle after address
- init_done  out  1  initialisation complete

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, init counter=1.
  - req_ready=0, rd_valid=0, rd1=rd2=0, init_done=0, ram_we=0.
  - Asserting reset mid-operation aborts everything and restarts INIT.
- INIT:
  - Each cycle: ram_we=1, ram_wa=counter, ram_wd=0; counter increments.
  - After writing address 31 (31 cycles), go to IDLE and set init_done=1 (registered).
  - wb_we is ignored in INIT; the core must not write before init_done (bench assertion).
- Writes in IDLE/READ/RESP:
  - ram_we = wb_we & (wb_wa != 0); ram_wa=wb_wa; ram_wd=wb_wd.
  - Writes are always accepted with no backpressure.
- Read addressing:
  - ram_ra1/ram_ra2 = ra1/ra2 (combinational) in the accept cycle.
  - Otherwise they hold the latched addresses ra1_q/ra2_q.
- req_ready = (state==IDLE) | (state==RESP & rd_ready). Never asserted in INIT or READ.
- Accept (req_valid & req_ready) in cycle N:
  - Latch ra1_q/ra2_q.
  - Record hit1_q = wb_we & wb_wa==ra1 & ra1!=0 with data wb_wd (likewise hit2_q).
  - Go to READ.
- READ (cycle N+1): operand k =
  - 0 if ra_k_q==0;
  - else wb_wd if a matching wb_we occurs this cycle;
  - else captured data if hit_k_q;
  - else ram_rd_k.
  - Registered into rd1/rd2; state becomes RESP; rd_valid=1 from cycle N+2.
  - Fixed latency: accept at N → rd_valid at N+2.
- RESP:
  - rd1/rd2 held stable while rd_valid & !rd_ready.
  - Exception: a write to a matching nonzero latched address updates the held value, so operands stay coherent.
  - rd_ready=1 with req_valid=1: accept back-to-back → READ, rd_valid=0 next cycle.
  - rd_ready=1 without req_valid: → IDLE, rd_valid=0.
- Throughput: one operand pair per 2 cycles.
- Same address on ra1 and ra2 is legal; both outputs are identical.

Optional Feature:
- Macro: REGFILE_CTRL_BYPASS_EN.
- Defined:
  - Forwarding behaves as specified above, covering the accept cycle, the READ cycle and RESP hold updates.
- Undefined:
  - No forwarding logic; rd_k = 0 for x0, else ram_rd_k.
  - req_ready is additionally gated by !wb_we, so no read is accepted during a write.
  - The pipeline guarantees no write targets a pending source during READ/RESP; the bench asserts this.

Test Plan:
1. Reset release → 31 cycles with ram_we=1 and ram_wa=1..31, ram_wd=0; init_done=1 on the next cycle. Read of x5 → rd1=0.
2. Write x3=0xDEADBEEF, later request ra1=3, ra2=0 → rd_valid exactly 2 cycles after accept; rd1=0xDEADBEEF, rd2=0.
3. Write x0=0x1234 → ram_we stays 0. A subsequent read of x0 → 0.
4. With BYPASS_EN:
   - Write x7=0xA5A5A5A5 in the accept cycle of ra1=7 → rd1=0xA5A5A5A5.
   - Write x7=0x5A5A5A5A during RESP with rd_ready=0 → rd1 becomes 0x5A5A5A5A.
5. rd_ready=0 for 4 cycles → rd_valid, rd1 and rd2 stable. Then rd_ready=1 with req_valid=1 → new request accepted the same cycle; new data 2 cycles later.
6. Drop rst_n in READ state → rd_valid=0 immediately, init_done=0, INIT restarts at address 1.
